// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shadow pipeline of in-flight GPR writes; raises load-use and
// HI/LO stalls and cross-checks the real WB stage against the shadow copy.
module hazard_scoreboard #(
    parameter int MD_LATENCY = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IDValid,
    input  logic [4:0]  IDRs,
    input  logic [4:0]  IDRt,
    input  logic        IDUseRs,
    input  logic        IDUseRt,
    input  logic        IDRegWr,
    input  logic [4:0]  IDRegWriteAddr,
    input  logic        IDMemToReg,
    input  logic        IDMDStart,
    input  logic        IDUseHiLo,
    input  logic        Flush,
    input  logic        WBRegWr,
    input  logic [4:0]  WBRegWriteAddr,
    output logic        Stall,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXBubble,
    output logic        MDBusy,
    output logic [31:0] PendingMask,
    output logic        ProtocolErr
);
    localparam logic [5:0] MD_LOAD = 6'(MD_LATENCY);
    // Loads past EX are forwarded, so only the EX slot keeps its load flag.
    logic       r_sex_v, r_smem_v, r_swb_v, r_sex_ld;
    logic [4:0] r_sex_addr, r_smem_addr, r_swb_addr;
    logic [5:0] r_md_count;
    logic       r_perr;
    logic       w_load_use, w_hilo_haz, w_issue, w_new_v, w_wb_act, w_wb_mm;
    logic [31:0] w_pend;

    assign w_load_use = r_sex_v && r_sex_ld &&
                        ((IDUseRs && r_sex_addr == IDRs) || (IDUseRt && r_sex_addr == IDRt));
    assign MDBusy     = r_md_count != 6'd0;
    assign w_hilo_haz = MDBusy && (IDUseHiLo || IDMDStart);
    assign Stall      = IDValid && (w_load_use || w_hilo_haz);
    assign PCWrite    = ~Stall;
    assign IFIDWrite  = ~Stall;
    assign IDEXBubble = Stall | Flush;
    assign w_issue    = IDValid && !Stall && !Flush;
    assign w_new_v    = w_issue && IDRegWr && IDRegWriteAddr != 5'd0;
    assign w_wb_act   = WBRegWr && WBRegWriteAddr != 5'd0;
    assign w_wb_mm    = (w_wb_act != r_swb_v) ||
                        (w_wb_act && r_swb_v && WBRegWriteAddr != r_swb_addr);
    assign ProtocolErr = r_perr;
    assign PendingMask = w_pend;

    always_comb begin
        w_pend = '0;
        if (r_sex_v)  w_pend[r_sex_addr]  = 1'b1;
        if (r_smem_v) w_pend[r_smem_addr] = 1'b1;
        if (r_swb_v)  w_pend[r_swb_addr]  = 1'b1;
        w_pend[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sex_v     <= 1'b0;
            r_sex_addr  <= 5'd0;
            r_sex_ld    <= 1'b0;
            r_smem_v    <= 1'b0;
            r_smem_addr <= 5'd0;
            r_swb_v     <= 1'b0;
            r_swb_addr  <= 5'd0;
            r_md_count  <= 6'd0;
            r_perr      <= 1'b0;
        end else begin
            r_swb_v     <= r_smem_v;
            r_swb_addr  <= r_smem_addr;
            r_smem_v    <= r_sex_v;
            r_smem_addr <= r_sex_addr;
            r_sex_v     <= w_new_v;
            r_sex_addr  <= w_new_v ? IDRegWriteAddr : 5'd0;
            r_sex_ld    <= w_new_v && IDMemToReg;
            r_md_count  <= (w_issue && IDMDStart) ? MD_LOAD :
                           MDBusy ? r_md_count - 6'd1 : 6'd0;
            r_perr      <= r_perr | w_wb_mm;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic checked against
// a history-based model of in-flight writes and mul/div busy windows.
module tb_hazard_scoreboard;
    localparam int L = 4;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic        IDValid = 0, IDUseRs = 0, IDUseRt = 0, IDRegWr = 0, IDMemToReg = 0;
    logic        IDMDStart = 0, IDUseHiLo = 0, Flush = 0, WBRegWr = 0;
    logic [4:0]  IDRs = 0, IDRt = 0, IDRegWriteAddr = 0, WBRegWriteAddr = 0;
    logic        Stall, PCWrite, IFIDWrite, IDEXBubble, MDBusy, ProtocolErr;
    logic [31:0] PendingMask;
    int n_cmp = 0, n_err = 0;

    typedef struct packed {logic v; logic [4:0] addr; logic ld;} ent_t;
    ent_t hist[$];
    int   cyc = 0, md_start = -1000;
    logic perr_m = 0;
    bit   wb_manual = 0;

    hazard_scoreboard #(.MD_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .IDValid(IDValid), .IDRs(IDRs), .IDRt(IDRt),
        .IDUseRs(IDUseRs), .IDUseRt(IDUseRt), .IDRegWr(IDRegWr),
        .IDRegWriteAddr(IDRegWriteAddr), .IDMemToReg(IDMemToReg), .IDMDStart(IDMDStart),
        .IDUseHiLo(IDUseHiLo), .Flush(Flush), .WBRegWr(WBRegWr),
        .WBRegWriteAddr(WBRegWriteAddr), .Stall(Stall), .PCWrite(PCWrite),
        .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble), .MDBusy(MDBusy),
        .PendingMask(PendingMask), .ProtocolErr(ProtocolErr)
    );

    always #5 clk = ~clk;

    // Entry issued k cycles ago (k=1 is in EX).
    function automatic ent_t slot(int k);
        if (hist.size() >= k) return hist[hist.size() - k];
        return '0;
    endfunction

    function automatic logic m_busy();
        return cyc > md_start && cyc <= md_start + L;
    endfunction

    function automatic logic m_stall();
        ent_t e = slot(1);
        logic lu = e.v && e.ld && ((IDUseRs && e.addr == IDRs) || (IDUseRt && e.addr == IDRt));
        return IDValid && (lu || (m_busy() && (IDUseHiLo || IDMDStart)));
    endfunction

    function automatic logic [31:0] m_pend();
        logic [31:0] m = '0;
        for (int k = 1; k <= 3; k++) begin
            ent_t e = slot(k);
            if (e.v) m[e.addr] = 1'b1;
        end
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_reset();
        hist.delete();
        cyc = 0;
        md_start = -1000;
        perr_m = 0;
    endtask

    // Advance model and clock by one cycle; WB inputs follow the model unless overridden.
    task automatic cycle();
        ent_t e3 = slot(3);
        ent_t ne = '0;
        logic iss = IDValid && !m_stall() && !Flush;
        logic act = WBRegWr && WBRegWriteAddr != 5'd0;
        if (act != e3.v || (act && e3.v && WBRegWriteAddr != e3.addr)) perr_m = 1;
        if (iss && IDRegWr && IDRegWriteAddr != 5'd0) ne = {1'b1, IDRegWriteAddr, IDMemToReg};
        hist.push_back(ne);
        if (hist.size() > 3) void'(hist.pop_front());
        if (iss && IDMDStart) md_start = cyc;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (!wb_manual) begin
            e3 = slot(3);
            WBRegWr = e3.v | ($urandom_range(0, 3) == 0);
            WBRegWriteAddr = e3.v ? e3.addr : 5'd0;
        end
    endtask

    task automatic set_id(logic v, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                          logic wr, logic [4:0] wa, logic ld, logic md, logic hl);
        IDValid = v; IDRs = rs; IDRt = rt; IDUseRs = urs; IDUseRt = urt;
        IDRegWr = wr; IDRegWriteAddr = wa; IDMemToReg = ld; IDMDStart = md; IDUseHiLo = hl;
    endtask

    task automatic idle(int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        Flush = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic test_reset();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        Flush = 1;
        #1 rst_n = 0;
        #1;
        n_cmp++;
        if ({Stall, PCWrite, IFIDWrite, IDEXBubble, MDBusy, ProtocolErr} !== 6'b011100) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 011100",
                     {Stall, PCWrite, IFIDWrite, IDEXBubble, MDBusy, ProtocolErr});
        end
        n_cmp++;
        if (PendingMask !== 32'd0) begin
            n_err++; $display("FAIL reset_mask: got %h want 0", PendingMask);
        end
        Flush = 0;
        #1;
        n_cmp++;
        if (IDEXBubble !== 1'b0) begin
            n_err++; $display("FAIL reset_bubble: got %b want 0", IDEXBubble);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        idle(1);
    endtask

    task automatic test_load_use();
        int cnt = 0;
        idle(3);
        set_id(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        #1;
        n_cmp++;
        if (Stall !== 1'b0) begin n_err++; $display("FAIL lu_issue: got %b want 0", Stall); end
        cycle();
        set_id(1, 5, 3, 1, 1, 1, 9, 0, 0, 0);
        #1;
        n_cmp++;
        if ({Stall, IDEXBubble, PCWrite, IFIDWrite} !== 4'b1100) begin
            n_err++; $display("FAIL lu_stall: got %b want 1100", {Stall, IDEXBubble, PCWrite, IFIDWrite});
        end
        cnt += PendingMask[5];
        cycle();
        #1;
        n_cmp++;
        if (Stall !== 1'b0) begin n_err++; $display("FAIL lu_release: got %b want 0", Stall); end
        for (int i = 0; i < 4; i++) begin
            #1;
            cnt += PendingMask[5];
            cycle();
            set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        n_cmp++;
        if (cnt != 3) begin n_err++; $display("FAIL lu_pend5: got %0d cycles want 3", cnt); end
        n_cmp++;
        if (PendingMask !== m_pend()) begin
            n_err++; $display("FAIL lu_mask: got %h want %h", PendingMask, m_pend());
        end
    endtask

    task automatic test_no_false_stall();
        idle(3);
        set_id(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); cycle();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        set_id(1, 5, 5, 1, 1, 1, 6, 0, 0, 0);
        #1;
        n_cmp++;
        if (Stall !== 1'b0) begin n_err++; $display("FAIL nfs_gap: got %b want 0", Stall); end
        cycle();
        set_id(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); cycle();
        set_id(1, 0, 0, 1, 1, 1, 7, 0, 0, 0);
        #1;
        n_cmp++;
        if (Stall !== 1'b0) begin n_err++; $display("FAIL nfs_r0: got %b want 0", Stall); end
        n_cmp++;
        if (PendingMask[0] !== 1'b0) begin n_err++; $display("FAIL nfs_bit0: got 1 want 0"); end
        cycle();
    endtask

    task automatic test_muldiv();
        int st = 0;
        idle(4);
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        set_id(1, 0, 0, 0, 0, 1, 4, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++;
            if (Stall !== m_stall()) begin
                n_err++; $display("FAIL md_stall_%0d: got %b want %b", i, Stall, m_stall());
            end
            if (!Stall) break;
            st++;
            cycle();
        end
        n_cmp++;
        if (st != L) begin n_err++; $display("FAIL md_len: got %0d want %0d", st, L); end
        n_cmp++;
        if (MDBusy !== 1'b0) begin n_err++; $display("FAIL md_idle: got %b want 0", MDBusy); end
        cycle();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        #1;
        n_cmp++;
        if ({Stall, MDBusy} !== 2'b11) begin
            n_err++; $display("FAIL md_second: got %b want 11", {Stall, MDBusy});
        end
        idle(L + 1);
    endtask

    task automatic test_flush();
        idle(4);
        set_id(1, 0, 0, 0, 0, 1, 6, 1, 0, 0);
        Flush = 1;
        #1;
        n_cmp++;
        if ({Stall, IDEXBubble} !== 2'b01) begin
            n_err++; $display("FAIL fl_bubble: got %b want 01", {Stall, IDEXBubble});
        end
        cycle();
        idle(0);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if ({ProtocolErr, PendingMask} !== 33'd0) begin
                n_err++; $display("FAIL fl_drain_%0d: got %b/%h want 0/0", i, ProtocolErr, PendingMask);
            end
            cycle();
        end
    endtask

    task automatic test_protocol();
        idle(4);
        set_id(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        cycle();
        idle(2);
        wb_manual = 1;
        WBRegWr = 1;
        WBRegWriteAddr = 5'd8;
        #1;
        n_cmp++;
        if (ProtocolErr !== 1'b0) begin n_err++; $display("FAIL pe_early: got %b want 0", ProtocolErr); end
        cycle();
        wb_manual = 0;
        WBRegWr = 0;
        WBRegWriteAddr = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (ProtocolErr !== 1'b1 || perr_m !== 1'b1) begin
                n_err++; $display("FAIL pe_sticky_%0d: got %b want 1", i, ProtocolErr);
            end
            cycle();
        end
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if (ProtocolErr !== 1'b0) begin n_err++; $display("FAIL pe_clear: got %b want 0", ProtocolErr); end
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_async_reset();
        idle(4);
        set_id(1, 0, 0, 0, 0, 1, 1, 0, 1, 0); cycle();
        set_id(1, 0, 0, 0, 0, 1, 2, 0, 0, 0); cycle();
        set_id(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if ({MDBusy, PendingMask} !== {1'b1, 32'h0000_000E}) begin
            n_err++; $display("FAIL ar_before: got %b/%h want 1/0000000e", MDBusy, PendingMask);
        end
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if ({MDBusy, Stall, PendingMask} !== 34'd0) begin
            n_err++; $display("FAIL ar_after: got %b/%b/%h want 0/0/0", MDBusy, Stall, PendingMask);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        WBRegWr = 0;
        WBRegWriteAddr = 0;
    endtask

    task automatic test_random();
        idle(4);
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
            Flush = $urandom_range(0, 7) == 0;
            #1;
            n_cmp++;
            if ({Stall, PCWrite, IFIDWrite, IDEXBubble, MDBusy, ProtocolErr} !==
                {m_stall(), !m_stall(), !m_stall(), m_stall() | Flush, m_busy(), perr_m}) begin
                n_err++;
                $display("FAIL rnd_ctrl_%0d: got %b want %b", i,
                         {Stall, PCWrite, IFIDWrite, IDEXBubble, MDBusy, ProtocolErr},
                         {m_stall(), !m_stall(), !m_stall(), m_stall() | Flush, m_busy(), perr_m});
            end
            n_cmp++;
            if (PendingMask !== m_pend()) begin
                n_err++; $display("FAIL rnd_mask_%0d: got %h want %h", i, PendingMask, m_pend());
            end
            cycle();
        end
        idle(0);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_muldiv();
        test_flush();
        test_protocol();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Writer-side pipeline control for the 5-stage pipelined CPU. It tracks every register write from issue (ID→EX) to writeback in a shadow pipeline, and raises the stall and bubble controls that forwarding alone cannot cover: load-use, and HI/LO access while the multi-cycle multiply/divide unit is busy. It sits beside the ID stage, drives the PC, IF/ID and ID/EX enables, and cross-checks the real WB stage against its own shadow copy.

## Interface
- MD_LATENCY, 32: cycles the mul/div unit stays busy after a start; legal range 1..63.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- IDValid  input  1  ID holds a real instruction.
- IDRs, IDRt  input  5 each  ID source register addresses.
- IDUseRs, IDUseRt  input  1 each  ID instruction actually reads Rs / Rt.
- IDRegWr  input  1  ID instruction writes a GPR.
- IDRegWriteAddr  input  5  its destination register.
- IDMemToReg  input  1  ID instruction is a load.
- IDMDStart  input  1  ID instruction starts mul/div.
- IDUseHiLo  input  1  ID instruction reads HI/LO (mfhi/mflo).
- Flush  input  1  branch/jump taken; the instruction in ID is killed.
- WBRegWr  input  1  actual WB-stage write enable.
- WBRegWriteAddr  input  5  actual WB-stage destination.
- Stall  output  1  hold IF/ID and PC this cycle.
- PCWrite, IFIDWrite  output  1 each  equal to ~Stall.
- IDEXBubble  output  1  load a NOP into ID/EX; equal to Stall | Flush.
- MDBusy  output  1  mul/div countdown is non-zero.
- PendingMask  output  32  one bit per GPR with an in-flight write; bit 0 is always 0.
- ProtocolErr  output  1  sticky WB mismatch flag.

## Operation
- Shadow pipeline: three registered slots, SEX, SMEM and SWB. Each slot holds {v, addr[4:0], ld}.
- Every clock edge the slots shift: SWB←SMEM, SMEM←SEX, SEX←new.
- Issue: new = {IDRegWr && IDRegWriteAddr!=0, IDRegWriteAddr, IDMemToReg} when IDValid && !Stall && !Flush. Otherwise new = all-zero.
- An invalid slot carries addr=0 and ld=0.
- LoadUse = SEX.v && SEX.ld && ((IDUseRs && SEX.addr==IDRs) || (IDUseRt && SEX.addr==IDRt)). Loads in SMEM or SWB are covered by forwarding and never stall.
- MD counter MDCount, 6 bits:
  - Loads MD_LATENCY on an issued instruction with IDMDStart.
  - Otherwise decrements while non-zero and holds at 0.
  - MDBusy = MDCount!=0.
- HiLoHaz = MDBusy && (IDUseHiLo || IDMDStart).
- Stall = IDValid && (LoadUse || HiLoHaz).
- Flush has priority over Stall for issue: nothing is issued. Stall is still reported, so PCWrite behaviour is decided by the branch logic upstream.
- PendingMask = OR of one-hot(addr) over the valid slots, with bit 0 forced to 0. The same register may appear in several slots.
- WB check, every cycle:
  - Actual write = WBRegWr && WBRegWriteAddr!=0.
  - Mismatch if the actual write differs from SWB.v, or if both are set and WBRegWriteAddr differs from SWB.addr.
  - A mismatch sets ProtocolErr on the next edge. Only reset clears it.

## Timing
- Reset, asynchronous: all slots zero, MDCount=0, ProtocolErr=0. While reset is asserted, Stall=0, PCWrite=IFIDWrite=1, IDEXBubble=Flush, MDBusy=0, PendingMask=0.
- Reset mid-operation discards all in-flight state immediately. There is no recovery of pending writes.
- Stall, IDEXBubble, PCWrite and IFIDWrite are combinational from the ID inputs and the registered state, with no added latency. The ID/EX register samples them at the same edge.
- Load-use stall lasts exactly 1 cycle: next edge SEX becomes a bubble and the load moves to SMEM.
- Issue at cycle t: entry is in SEX at t+1, SMEM at t+2, SWB at t+3. WB inputs are compared at t+3.
- Mul/div start issued at edge t: MDBusy is 1 for cycles t+1 .. t+MD_LATENCY and 0 at t+MD_LATENCY+1.
- A dependent mfhi waits in ID and issues at the first cycle MDBusy=0.
- Simultaneous load-use and HiLoHaz produce a single Stall. A stalled instruction re-evaluates every cycle.
- A write to $0 is never tracked, never stalls and never raises ProtocolErr.

## Test plan
- Load-use: issue lw $5 (IDMemToReg=1), then ID add reads Rs=$5 → Stall=1 and IDEXBubble=1 for 1 cycle. Add issues next cycle; PendingMask[5]=1 for 3 cycles in total.
- No false stall: lw $5, then nop, then add $5 → Stall never asserts. Also lw $0 followed by a reader of $0 → no stall.
- Mul/div: MD_LATENCY=4, issue mult at edge t, mflo in ID → Stall high for cycles t+1..t+4, mflo issues at t+5. A second mult during busy also stalls.
- Flush: Flush=1 with a valid lw in ID → SEX bubble. Three cycles later SWB.v=0, and WBRegWr=0 raises no ProtocolErr.
- Protocol check: issue add $7, then drive WBRegWriteAddr=8 at t+3 → ProtocolErr=1 from t+4. It remains 1 until rst_n=0.
- Async reset mid-stream: with three valid slots and MDCount=10, pull rst_n low between edges → PendingMask=0 and MDBusy=0 immediately.
